// File: rtl/mips_mc_core_ctrl_if.sv
// Bus bundle for the multi-cycle MIPS-style control unit: instruction fetch
// handshake, external ALU operands/result and the architectural status outputs.
interface mips_mc_core_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_valid;
  logic [3:0]    alu_ctrl;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_y;
  logic [AW-1:0] pc;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          retire;
  logic          halt;
  logic          err;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_valid,
    output alu_ctrl, alu_a, alu_b,
    input  alu_y,
    output pc, wb_en, wb_addr, wb_data, retire, halt, err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_valid,
    input  alu_ctrl, alu_a, alu_b,
    output alu_y,
    input  pc, wb_en, wb_addr, wb_data, retire, halt, err
  );
endinterface

// File: rtl/mips_mc_core_ctrl.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXEC -> WB, one instruction
// retired per four cycles plus fetch wait. Owns the GPR file and the PC,
// drives an external combinational ALU and resolves branches locally.
module mips_mc_core_ctrl #(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter int            NREG     = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            ZERO_R0  = 1
) (
  input  logic                clk,
  input  logic                rst,
  mips_mc_core_ctrl_if.master bus
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic signed [DW-1:0] ZERO_S = '0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Architectural / control state
  logic [AW-1:0] pc_q;
  logic          imem_req_q;
  logic          err_q;
  logic [3:0]    alu_ctrl_q;
  logic [DW-1:0] alu_a_q;
  logic [DW-1:0] alu_b_q;
  logic [DW-1:0] gpr [NREG];

  // Per-instruction datapath latches
  logic [31:0]          ir_q;
  logic signed [DW-1:0] a_q;
  logic signed [DW-1:0] b_q;
  logic [DW-1:0]        y_q;
  logic                 taken_q;

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [3:0]  shamt, funct4;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [RW-1:0] rd_idx, rs1_idx, rs2_idx;

  assign op      = ir_q[31:26];
  assign rd_f    = ir_q[25:21];
  assign rs1_f   = ir_q[20:16];
  assign rs2_f   = ir_q[15:11];
  assign shamt   = ir_q[10:7];
  assign funct4  = ir_q[3:0];
  assign imm     = ir_q[15:0];
  assign jaddr   = ir_q[25:0];
  assign rd_idx  = rd_f[RW-1:0];
  assign rs1_idx = rs1_f[RW-1:0];
  assign rs2_idx = rs2_f[RW-1:0];

  // Instruction classes
  logic is_r, is_i, is_br, is_j, is_halt, legal, writes, imm_zext;

  assign is_r     = (op == 6'b000000);
  assign is_i     = (op[5:4] == 2'b01);
  assign is_br    = (op[5:3] == 3'b001);
  assign is_j     = (op == 6'b000010);
  assign is_halt  = (op == 6'b111111);
  assign writes   = is_r | is_i;
  assign imm_zext = (op[3:2] == 2'b10) || (op[3:1] == 3'b111);

  function automatic logic [DW-1:0] sext16(input logic [15:0] v);
    return DW'($signed(v));
  endfunction

  function automatic logic [DW-1:0] zext16(input logic [15:0] v);
    return DW'(v);
  endfunction

  // ALU codes 011x and 110x have no defined operation.
  function automatic logic code_legal(input logic [3:0] c);
    return !((c[3:1] == 3'b011) || (c[3:1] == 3'b110));
  endfunction

  assign legal = (is_r && code_legal(funct4)) || (is_i && code_legal(op[3:0])) ||
                 is_br || is_j || is_halt;

  logic fetch_acc;
  assign fetch_acc = (state_q == S_FETCH) && imem_req_q && bus.imem_valid;

  // GPR read ports, with r0 hardwired to zero when enabled
  logic [DW-1:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = gpr[rs1_idx];
    rs2_val = gpr[rs2_idx];
    if ((ZERO_R0 != 0) && (rs1_idx == '0)) rs1_val = '0;
    if ((ZERO_R0 != 0) && (rs2_idx == '0)) rs2_val = '0;
  end

  // Signed branch condition evaluated on the latched operands
  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (op[2:0])
      3'b000:  br_taken = (a_q == b_q);
      3'b001:  br_taken = (a_q != b_q);
      3'b010:  br_taken = (a_q == ZERO_S);
      3'b011:  br_taken = (a_q != ZERO_S);
      3'b100:  br_taken = (a_q <  b_q);
      3'b101:  br_taken = (a_q >  b_q);
      3'b110:  br_taken = (a_q >= ZERO_S);
      default: br_taken = (a_q <= ZERO_S);
    endcase
  end

  // ALU operand selection presented during EXEC
  logic [3:0]    exec_ctrl;
  logic [DW-1:0] exec_a, exec_b;
  always_comb begin
    exec_ctrl = 4'b0000;
    exec_a    = a_q;
    exec_b    = b_q;
    if (is_r) begin
      exec_ctrl = funct4;
      if (funct4[3:1] == 3'b111) exec_b = DW'(shamt);
    end else if (is_i) begin
      exec_ctrl = op[3:0];
      exec_b    = imm_zext ? zext16(imm) : sext16(imm);
    end else if (is_br) begin
      exec_ctrl = 4'b0110;
    end
  end

  // PC update applied at the end of WB
  logic [AW-1:0] pc_next;
  always_comb begin
    pc_next = pc_q + AW'(4);
    if (is_br && taken_q) pc_next = AW'({imm, 2'b00});
    else if (is_j)        pc_next = AW'({jaddr, 2'b00});
    else if (is_halt)     pc_next = pc_q;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // FSM next-state logic; HALT is left only through rst
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (fetch_acc) state_d = S_DECODE;
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = is_halt ? S_HALT : S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // FSM outputs: WB pulses, ALU drive (live in EXEC, held otherwise), status
  logic          retire_c, wb_en_c, halt_c;
  logic [3:0]    alu_ctrl_c;
  logic [DW-1:0] alu_a_c, alu_b_c;
  always_comb begin
    retire_c   = (state_q == S_WB);
    wb_en_c    = (state_q == S_WB) && writes && !((ZERO_R0 != 0) && (rd_idx == '0));
    halt_c     = (state_q == S_HALT);
    alu_ctrl_c = alu_ctrl_q;
    alu_a_c    = alu_a_q;
    alu_b_c    = alu_b_q;
    if (state_q == S_EXEC) begin
      alu_ctrl_c = exec_ctrl;
      alu_a_c    = exec_a;
      alu_b_c    = exec_b;
    end
  end

  // Control state: fetch request, PC, error flag, ALU hold registers, GPRs
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req_q <= 1'b0;
      pc_q       <= RESET_PC;
      err_q      <= 1'b0;
      alu_ctrl_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      imem_req_q <= (state_d == S_FETCH);
      if (state_q == S_WB) pc_q <= pc_next;
      if ((state_q == S_DECODE) && !legal) err_q <= 1'b1;
      if (state_q == S_EXEC) begin
        alu_ctrl_q <= exec_ctrl;
        alu_a_q    <= exec_a;
        alu_b_q    <= exec_b;
      end
      if (wb_en_c) gpr[rd_idx] <= y_q;
    end
  end

  // Datapath latches: IR at fetch, operands at decode, result and branch at exec
  always_ff @(posedge clk) begin
    if (fetch_acc) ir_q <= bus.imem_rdata;
    if (state_q == S_DECODE) begin
      a_q <= rs1_val;
      b_q <= rs2_val;
    end
    if (state_q == S_EXEC) begin
      y_q     <= bus.alu_y;
      taken_q <= br_taken;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.alu_ctrl  = alu_ctrl_c;
  assign bus.alu_a     = alu_a_c;
  assign bus.alu_b     = alu_b_c;
  assign bus.wb_en     = wb_en_c;
  assign bus.wb_addr   = 5'(rd_idx);
  assign bus.wb_data   = y_q;
  assign bus.retire    = retire_c;
  assign bus.halt      = halt_c;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mips_mc_core_ctrl.sv
// Bench for mips_mc_core_ctrl: directed scenarios plus a random instruction
// stream, checked against an instruction-level model of the architecture.
module tb_mips_mc_core_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  mips_mc_core_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  mips_mc_core_ctrl_if #(.DW(DW), .AW(AW)) bus2 ();

  mips_mc_core_ctrl #(.DW(DW), .AW(AW), .NREG(32), .RESET_PC('0), .ZERO_R0(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mips_mc_core_ctrl #(.DW(DW), .AW(AW), .NREG(32), .RESET_PC(32'hFFFF_FFFC), .ZERO_R0(1)) u_dut_wrap (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  // Bench-side ALU
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return a - b;
      4'd8:  return {31'd0, $signed(a) < $signed(b)};
      4'd9:  return {31'd0, a < b};
      4'd10: return b << 16;
      4'd11: return ~a;
      4'd14: return a << b[4:0];
      4'd15: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always_comb bus.alu_y  = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  always_comb bus2.alu_y = alu_fn(bus2.alu_ctrl, bus2.alu_a, bus2.alu_b);

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural model
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;

  typedef struct packed {
    logic        legal;
    logic        is_halt;
    logic        chk_ab;
    logic        chk_ctrl;
    logic        wb;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] wdata;
    logic [31:0] next_pc;
  } exp_t;

  function automatic logic [31:0] rv(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : m_reg[i];
  endfunction

  function automatic logic bad_code(input int c);
    return (c == 6) || (c == 7) || (c == 12) || (c == 13);
  endfunction

  function automatic exp_t model_exec(input logic [31:0] ir);
    exp_t e;
    int op, code, cond;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm, shamt;
    logic signed [31:0] sa, sb;
    logic tk;
    op    = int'(ir[31:26]);
    rd    = ir[25:21];
    rs1   = ir[20:16];
    rs2   = ir[15:11];
    shamt = 32'(ir[10:7]);
    imm   = 32'(ir[15:0]);
    e = '0;
    e.legal   = 1'b1;
    e.rd      = rd;
    e.next_pc = m_pc + 32'd4;
    if (op == 0) begin
      code = int'(ir[3:0]);
      e.legal = !bad_code(code);
      e.ctrl = 4'(code);
      e.a = rv(rs1);
      e.b = (code >= 14) ? shamt : rv(rs2);
      e.chk_ab = 1'b1; e.chk_ctrl = 1'b1;
      e.wb = (rd != 5'd0);
    end else if (op >= 16 && op < 32) begin
      code = op - 16;
      e.legal = !bad_code(code);
      e.ctrl = 4'(code);
      e.a = rv(rs1);
      e.b = (code >= 8) ? imm : ((imm >= 32'd32768) ? (imm | 32'hFFFF_0000) : imm);
      e.chk_ab = 1'b1; e.chk_ctrl = 1'b1;
      e.wb = (rd != 5'd0);
    end else if (op >= 8 && op < 16) begin
      cond = op - 8;
      sa = $signed(rv(rs1));
      sb = $signed(rv(rs2));
      case (cond)
        0: tk = (sa == sb);
        1: tk = (sa != sb);
        2: tk = (sa == 0);
        3: tk = (sa != 0);
        4: tk = (sa < sb);
        5: tk = (sa > sb);
        6: tk = (sa >= 0);
        default: tk = (sa <= 0);
      endcase
      e.ctrl = 4'b0110;
      e.chk_ctrl = 1'b1;
      if (tk) e.next_pc = imm * 4;
    end else if (op == 2) begin
      e.next_pc = 32'(ir[25:0]) * 4;
    end else if (op == 63) begin
      e.is_halt = 1'b1;
      e.next_pc = m_pc;
    end else begin
      e.legal = 1'b0;
    end
    e.wdata = alu_fn(e.ctrl, e.a, e.b);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_pc = 32'd0;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [3:0] f4, input logic [3:0] sh);
    return {6'b000000, rd, rs1, rs2, sh, 3'b000, f4};
  endfunction

  function automatic logic [31:0] enc_i(input logic [3:0] code, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [15:0] imm);
    return {2'b01, code, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] cond, input logic [4:0] rs1, input logic [15:0] imm);
    return {3'b001, cond, 5'd0, rs1, imm};
  endfunction

  logic [3:0] legal_codes [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14, 4'd15};

  function automatic logic [31:0] rand_instr();
    int k;
    logic [4:0] rd, rs1, rs2;
    logic [3:0] c;
    k   = int'($urandom_range(0, 9));
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    c   = legal_codes[$urandom_range(0, 11)];
    if (k < 4)      return {6'b000000, rd, rs1, rs2, 4'($urandom), 3'($urandom), c};
    else if (k < 8) return enc_i(c, rd, rs1, 16'($urandom));
    else if (k < 9) return enc_b(3'($urandom), rs1, 16'($urandom));
    else            return {6'b000010, 26'($urandom)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_pc", bus.pc, 32'd0);
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_retire", 32'(bus.retire), 32'd0);
    check_eq("rst_wb_en", 32'(bus.wb_en), 32'd0);
    check_eq("rst_halt", 32'(bus.halt), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check_eq("rst_alu_a", bus.alu_a, 32'd0);
    check_eq("rst_alu_b", bus.alu_b, 32'd0);
    rst = 1'b0;
    model_reset();
    tick();
    check_eq("post_rst_req", 32'(bus.imem_req), 32'd1);
    check_eq("post_rst_addr", bus.imem_addr, 32'd0);
  endtask

  // Wait for a fetch request, stall dly cycles, deliver ir, then follow the
  // instruction to its retirement (or to the illegal-op halt).
  task automatic do_instr(input logic [31:0] ir, input int dly);
    exp_t e;
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq("req_wait", 32'(bus.imem_req), 32'd1);
    check_eq("imem_addr", bus.imem_addr, m_pc);
    e = model_exec(ir);
    for (int i = 0; i < dly; i++) begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = $urandom;
      tick();
      check_eq("req_held", 32'(bus.imem_req), 32'd1);
      check_eq("stall_retire", 32'(bus.retire), 32'd0);
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = ir;
    tick();
    bus.imem_valid = 1'($urandom_range(0, 1));
    bus.imem_rdata = $urandom;
    check_eq("req_drop", 32'(bus.imem_req), 32'd0);
    check_eq("dec_retire", 32'(bus.retire), 32'd0);
    tick();
    if (!e.legal) begin
      check_eq("ill_err", 32'(bus.err), 32'd1);
      check_eq("ill_halt", 32'(bus.halt), 32'd1);
      for (int i = 0; i < 3; i++) begin
        bus.imem_valid = 1'b1;
        check_eq("ill_req", 32'(bus.imem_req), 32'd0);
        check_eq("ill_retire", 32'(bus.retire), 32'd0);
        check_eq("ill_wb_en", 32'(bus.wb_en), 32'd0);
        tick();
      end
      bus.imem_valid = 1'b0;
      return;
    end
    check_eq("exec_retire", 32'(bus.retire), 32'd0);
    if (e.chk_ctrl) check_eq("exec_alu_ctrl", 32'(bus.alu_ctrl), 32'(e.ctrl));
    if (e.chk_ab) begin
      check_eq("exec_alu_a", bus.alu_a, e.a);
      check_eq("exec_alu_b", bus.alu_b, e.b);
    end
    tick();
    check_eq("wb_retire", 32'(bus.retire), 32'd1);
    check_eq("wb_en", 32'(bus.wb_en), 32'(e.wb));
    if (e.wb) begin
      check_eq("wb_addr", 32'(bus.wb_addr), 32'(e.rd));
      check_eq("wb_data", bus.wb_data, e.wdata);
    end
    if (e.chk_ab) begin
      check_eq("hold_alu_ctrl", 32'(bus.alu_ctrl), 32'(e.ctrl));
      check_eq("hold_alu_b", bus.alu_b, e.b);
    end
    bus.imem_valid = 1'b0;
    tick();
    if (e.wb) m_reg[e.rd] = e.wdata;
    m_pc = e.next_pc;
    check_eq("pc", bus.pc, m_pc);
    check_eq("post_retire", 32'(bus.retire), 32'd0);
    if (e.is_halt) begin
      check_eq("halt_flag", 32'(bus.halt), 32'd1);
      check_eq("halt_req", 32'(bus.imem_req), 32'd0);
      check_eq("halt_err", 32'(bus.err), 32'd0);
    end else begin
      check_eq("next_req", 32'(bus.imem_req), 32'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_valid  = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus2.imem_valid = 1'b0;
    bus2.imem_rdata = 32'd0;
    model_reset();

    // Reset state and first fetch
    do_reset();

    // ADDI r1,r0,5 ; ADD r2,r1,r1
    do_instr(enc_i(4'd0, 5'd1, 5'd0, 16'd5), 0);
    do_instr(enc_r(5'd2, 5'd1, 5'd1, 4'd0, 4'd0), 0);
    check_eq("t2_pc", bus.pc, 32'd8);

    // Delayed fetch data
    do_instr(enc_r(5'd3, 5'd2, 5'd1, 4'd1, 4'd0), 3);

    // Branches on a negative operand
    do_instr(enc_i(4'd0, 5'd1, 5'd0, 16'hFFFF), 0);
    do_instr(enc_b(3'd4, 5'd1, 16'h0010), 0);
    check_eq("t4_taken_pc", bus.pc, 32'h40);
    do_instr(enc_b(3'd6, 5'd1, 16'h0010), 0);
    check_eq("t4_not_taken_pc", bus.pc, 32'h44);

    // Shift with shamt and a zero-extended immediate
    do_instr(enc_r(5'd4, 5'd1, 5'd0, 4'd15, 4'd9), 1);
    do_instr(enc_i(4'd10, 5'd5, 5'd1, 16'h8001), 0);

    // Writes to r0 are dropped
    do_instr(enc_i(4'd0, 5'd0, 5'd0, 16'd7), 0);
    do_instr(enc_r(5'd6, 5'd0, 5'd0, 4'd0, 4'd0), 0);

    // Illegal opcode, illegal funct, illegal immediate code
    do_instr({6'b000111, 26'd0}, 0);
    do_reset();
    do_instr(enc_r(5'd1, 5'd0, 5'd0, 4'd6, 4'd0), 0);
    do_reset();
    do_instr(enc_i(4'd12, 5'd1, 5'd0, 16'd1), 0);
    do_reset();

    // HALT
    do_instr(enc_i(4'd0, 5'd1, 5'd0, 16'd9), 0);
    do_instr(32'hFC00_0000, 0);
    tick();
    check_eq("halt_sticky", 32'(bus.halt), 32'd1);
    do_reset();

    // Reset during EXEC of ADD r3,r1,r2
    do_instr(enc_i(4'd0, 5'd1, 5'd0, 16'd3), 0);
    do_instr(enc_i(4'd0, 5'd2, 5'd0, 16'd4), 0);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = enc_r(5'd3, 5'd1, 5'd2, 4'd0, 4'd0);
    tick();
    bus.imem_valid = 1'b0;
    tick();
    check_eq("t6_exec_alu_a", bus.alu_a, 32'd3);
    rst = 1'b1;
    tick();
    check_eq("t6_req", 32'(bus.imem_req), 32'd0);
    check_eq("t6_pc", bus.pc, 32'd0);
    check_eq("t6_retire", 32'(bus.retire), 32'd0);
    check_eq("t6_wb_en", 32'(bus.wb_en), 32'd0);
    rst = 1'b0;
    model_reset();
    tick();
    do_instr(enc_r(5'd4, 5'd3, 5'd0, 4'd0, 4'd0), 0);

    // PC wrap from 0xFFFFFFFC
    check_eq("wrap_rst_pc", bus2.pc, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    tick();
    check_eq("wrap_req", 32'(bus2.imem_req), 32'd1);
    check_eq("wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    bus2.imem_valid = 1'b1;
    bus2.imem_rdata = enc_i(4'd0, 5'd1, 5'd0, 16'd1);
    tick();
    bus2.imem_valid = 1'b0;
    tick();
    tick();
    check_eq("wrap_retire", 32'(bus2.retire), 32'd1);
    check_eq("wrap_wb_data", bus2.wb_data, 32'd1);
    tick();
    check_eq("wrap_pc", bus2.pc, 32'd0);
    check_eq("wrap_next_addr", bus2.imem_addr, 32'd0);

    // Random instruction stream
    do_reset();
    for (int i = 0; i < 150; i++) begin
      do_instr(rand_instr(), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
